iru_rot_gather: RTL and testbench

//  Rotation gather stage of the IRU; sits directly downstream of iru_comp_unit.

---
 rtl/iru_pkg.sv | 22 ++
 rtl/iru_rot_gather_if.sv | 33 +++
 rtl/iru_img_buf.sv | 37 +++
 rtl/iru_rot_gather.sv | 166 ++++++++++++++++
 tb/tb_iru_rot_gather.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/iru_pkg.sv
// Shared IRU constants, types and address helper used by the rotation gather stage.
package iru_pkg;

    localparam int unsigned IRU_DIM  = 20;
    localparam int unsigned IRU_NPIX = IRU_DIM * IRU_DIM;

    typedef logic [8:0] iru_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        DRAIN = 2'd3
    } iru_gather_state_e;

    // Raster address of (row,col) in a window of side dim; 9 bits cover dim<=22.
    function automatic iru_addr_t iru_rc_addr(input logic [4:0] row, input logic [4:0] col,
                                              input iru_addr_t dim);
        return iru_addr_t'(row) * dim + iru_addr_t'(col);
    endfunction

endpackage

// File: rtl/iru_rot_gather_if.sv
// Source and result pixel streams of the rotation gather stage.
// Optional IRU_GATHER_MASK_EN adds out_oob (pixel substituted by FILL).
interface iru_rot_gather_if #(
    parameter int unsigned PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pix;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pix;
    logic             out_last;
`ifdef IRU_GATHER_MASK_EN
    logic             out_oob;
`endif

    modport master (
        output in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_pix, out_last
`ifdef IRU_GATHER_MASK_EN
        , input out_oob
`endif
    );

    modport slave (
        input  in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_pix, out_last
`ifdef IRU_GATHER_MASK_EN
        , output out_oob
`endif
    );

endinterface

// File: rtl/iru_img_buf.sv
// One-window pixel store: synchronous write, combinational read; contents are not reset.
module iru_img_buf
    import iru_pkg::*;
#(
    parameter int unsigned NPIX  = IRU_NPIX,
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  iru_addr_t        waddr_i,
    input  logic [PIX_W-1:0] wdata_i,
    input  iru_addr_t        raddr_i,
    output logic [PIX_W-1:0] rdata_o
);

    localparam iru_addr_t NPIX_A = iru_addr_t'(NPIX);

    logic [PIX_W-1:0] mem_q [NPIX];

    // Pixel write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port; addresses past the window read as zero.
    always_comb begin
        rdata_o = {PIX_W{1'b0}};
        if (raddr_i < NPIX_A) begin
            rdata_o = mem_q[raddr_i];
        end else begin
            rdata_o = {PIX_W{1'b0}};
        end
    end

endmodule

// File: rtl/iru_rot_gather.sv
// Rotation gather: buffers a DIMxDIM window, sweeps destinations through the rotation
// unit and streams source pixels (FILL when out of window). Option: IRU_GATHER_MASK_EN.
module iru_rot_gather
    import iru_pkg::*;
#(
    parameter int unsigned      DIM   = IRU_DIM,
    parameter int unsigned      PIX_W = 8,
    parameter logic [PIX_W-1:0] FILL  = {PIX_W{1'b0}}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [35:0] rnn_d,
    output logic        idle,
    output logic [35:0] rnn_q,
    output logic [4:0]  comp_row,
    output logic [4:0]  comp_col,
    input  logic        comp_valid,
    input  logic [4:0]  comp_row_q,
    input  logic [4:0]  comp_col_q,
    output logic        done,
    iru_rot_gather_if.slave pix_if
);

    localparam iru_addr_t  DIM_A  = iru_addr_t'(DIM);
    localparam iru_addr_t  LAST_A = iru_addr_t'(DIM * DIM - 1);
    localparam logic [4:0] DIM_C  = 5'(DIM);
    localparam logic [4:0] LAST_C = 5'(DIM - 1);

    iru_gather_state_e state_q, state_d;
    iru_addr_t         lcnt_q, lcnt_d;
    logic [4:0]        row_q, row_d, col_q, col_d;
    logic [35:0]       rnn_next_d;
    logic              out_valid_q, out_valid_d;
    logic [PIX_W-1:0]  out_pix_q, out_pix_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              oob_q, oob_d;
    logic              adv_s, src_ok_s, we_s;
    logic [PIX_W-1:0]  rd_pix_s;

    assign adv_s    = !out_valid_q || pix_if.out_ready;
    // A valid coordinate outside the window is still treated as a miss.
    assign src_ok_s = comp_valid && (comp_row_q < DIM_C) && (comp_col_q < DIM_C);
    assign we_s     = (state_q == LOAD) && pix_if.in_valid;

    iru_img_buf #(.NPIX(DIM * DIM), .PIX_W(PIX_W)) u_buf (
        .clk     (clk),
        .we_i    (we_s),
        .waddr_i (lcnt_q),
        .wdata_i (pix_if.in_pix),
        .raddr_i (iru_rc_addr(comp_row_q, comp_col_q, DIM_A)),
        .rdata_o (rd_pix_s)
    );

    // Next-state and datapath update for the IDLE/LOAD/SWEEP/DRAIN sequence.
    always_comb begin
        state_d     = state_q;
        lcnt_d      = lcnt_q;
        row_d       = row_q;
        col_d       = col_q;
        rnn_next_d  = rnn_q;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        out_last_d  = out_last_q;
        oob_d       = oob_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rnn_next_d = rnn_d;
                    lcnt_d     = 9'd0;
                    state_d    = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (pix_if.in_valid && lcnt_q == LAST_A) begin
                    lcnt_d  = 9'd0;
                    row_d   = 5'd0;
                    col_d   = 5'd0;
                    state_d = SWEEP;
                end else if (pix_if.in_valid) begin
                    lcnt_d = lcnt_q + 9'd1;
                end else begin
                    lcnt_d = lcnt_q;
                end
            end
            SWEEP: begin
                if (adv_s) begin
                    out_valid_d = 1'b1;
                    out_pix_d   = src_ok_s ? rd_pix_s : FILL;
                    oob_d       = !src_ok_s;
                    out_last_d  = (row_q == LAST_C) && (col_q == LAST_C);
                    if (row_q == LAST_C && col_q == LAST_C) begin
                        state_d = DRAIN;
                    end else if (col_q == LAST_C) begin
                        col_d = 5'd0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end else begin
                    state_d = SWEEP;
                end
            end
            DRAIN: begin
                if (pix_if.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lcnt_q      <= 9'd0;
            row_q       <= 5'd0;
            col_q       <= 5'd0;
            rnn_q       <= 36'd0;
            out_valid_q <= 1'b0;
            out_pix_q   <= {PIX_W{1'b0}};
            out_last_q  <= 1'b0;
            oob_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lcnt_q      <= lcnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rnn_q       <= rnn_next_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_last_q  <= out_last_d;
            oob_q       <= oob_d;
            done_q      <= done_d;
        end
    end

    assign idle             = (state_q == IDLE);
    assign pix_if.in_ready  = (state_q == LOAD);
    assign comp_row         = row_q;
    assign comp_col         = col_q;
    assign pix_if.out_valid = out_valid_q;
    assign pix_if.out_pix   = out_pix_q;
    assign pix_if.out_last  = out_last_q;
    assign done             = done_q;
`ifdef IRU_GATHER_MASK_EN
    assign pix_if.out_oob   = oob_q;
`else
    logic unused_oob_s;
    assign unused_oob_s = oob_q;
`endif

endmodule

// File: tb/tb_iru_rot_gather.sv
// Self-checking bench for iru_rot_gather with a behavioural rotation-unit model and a
// window-level reference model (identity, transpose, all-invalid, out-of-range, control).
module tb_iru_rot_gather;

    localparam int N    = 400;
    localparam int OORK = 57;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [35:0] rnn_d;
    logic        idle;
    logic [35:0] rnn_q;
    logic [4:0]  comp_row, comp_col, comp_row_q, comp_col_q;
    logic        comp_valid;
    logic        done;
    int          mode;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  img [N];

    iru_rot_gather_if #(.PIX_W(8)) pif ();

    iru_rot_gather dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rnn_d      (rnn_d),
        .idle       (idle),
        .rnn_q      (rnn_q),
        .comp_row   (comp_row),
        .comp_col   (comp_col),
        .comp_valid (comp_valid),
        .comp_row_q (comp_row_q),
        .comp_col_q (comp_col_q),
        .done       (done),
        .pix_if     (pif)
    );

    always #5 clk = ~clk;

    // Behavioural rotation unit: 0 identity, 1 transpose, 2 never valid, 3 identity with one bad col.
    always_comb begin
        comp_valid = 1'b1;
        comp_row_q = comp_row;
        comp_col_q = comp_col;
        case (mode)
            1: begin comp_row_q = comp_col; comp_col_q = comp_row; end
            2: comp_valid = 1'b0;
            3: if (int'(comp_row) * 20 + int'(comp_col) == OORK) comp_col_q = 5'd25;
            default: ;
        endcase
    end

    // Reference: destination k gets the source pixel the rotation maps to, FILL if outside.
    function automatic bit src_ok(input int k, output int src);
        int r = k / 20, c = k % 20;
        int sr = r, sc = c;
        bit v = 1'b1;
        if (mode == 1) begin sr = c; sc = r; end
        if (mode == 2) v = 1'b0;
        if (mode == 3 && k == OORK) sc = 25;
        src = sr * 20 + sc;
        return v && sr < 20 && sc < 20;
    endfunction

    function automatic logic [7:0] exp_pix(input int k);
        int s;
        if (src_ok(k, s)) return img[s];
        return 8'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_window(input logic [35:0] r);
        @(negedge clk);
        start = 1'b1;
        rnn_d = r;
        @(negedge clk);
        start = 1'b0;
        rnn_d = 36'd0;
        check("start_idle", idle, 1'b0);
        check("rnn_latch", rnn_q, r);
        check("in_ready_load", pif.in_ready, 1'b1);
    endtask

    task automatic load(input int n, input bit gaps);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            pif.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            pif.in_pix   = img[idx];
            if (pif.in_valid && pif.in_ready) idx++;
        end
        check("load_count", idx, n);
    endtask

    task automatic collect(input bit bp, input bit noise);
        int acc = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [7:0] spix = 8'd0;
        logic slast = 1'b0;
        int s;
        while (acc < N && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            pif.in_valid = 1'b0;
            if (stalled) begin
                check("stall_valid", pif.out_valid, 1'b1);
                check("stall_pix", pif.out_pix, spix);
                check("stall_last", pif.out_last, slast);
            end
            check("done_early", done, 1'b0);
            start = noise && cyc <= 40;
            rnn_d = {4'($urandom), 32'($urandom)};
            pif.out_ready = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (pif.out_valid && pif.out_ready) begin
                check("pix", pif.out_pix, exp_pix(acc));
                check("last", pif.out_last, acc == N - 1);
`ifdef IRU_GATHER_MASK_EN
                check("oob", pif.out_oob, !src_ok(acc, s));
`endif
                acc++;
                stalled = 1'b0;
            end else begin
                stalled = pif.out_valid;
                spix    = pif.out_pix;
                slast   = pif.out_last;
            end
        end
        start = 1'b0;
        check("beats", acc, N);
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("idle_after", idle, 1'b1);
        check("valid_after", pif.out_valid, 1'b0);
        @(negedge clk);
        check("done_once", done, 1'b0);
        check("no_extra_beat", pif.out_valid, 1'b0);
    endtask

    task automatic run_window(input int m, input bit rnd_img, input bit bp, input bit noise);
        logic [35:0] r;
        r = {4'($urandom), 32'($urandom)};
        mode = m;
        for (int k = 0; k < N; k++) img[k] = rnd_img ? 8'($urandom) : 8'(k);
        start_window(r);
        load(N, bp);
        collect(bp, noise);
        check("rnn_hold", rnn_q, r);
    endtask

    task automatic check_reset_state();
        check("rst_idle", idle, 1'b1);
        check("rst_in_ready", pif.in_ready, 1'b0);
        check("rst_out_valid", pif.out_valid, 1'b0);
        check("rst_out_pix", pif.out_pix, 8'd0);
        check("rst_out_last", pif.out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rnn", rnn_q, 36'd0);
`ifdef IRU_GATHER_MASK_EN
        check("rst_oob", pif.out_oob, 1'b0);
`endif
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        rnn_d         = 36'd0;
        mode          = 0;
        pif.in_valid  = 1'b0;
        pif.in_pix    = 8'd0;
        pif.out_ready = 1'b0;
        #12;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        run_window(0, 1'b0, 1'b0, 1'b0);
        run_window(1, 1'b1, 1'b1, 1'b1);
        run_window(2, 1'b1, 1'b0, 1'b0);
        run_window(3, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of LOAD discards the partial window.
        mode = 0;
        for (int k = 0; k < N; k++) img[k] = 8'($urandom);
        start_window(36'h9_1234_5678);
        load(150, 1'b0);
        @(negedge clk);
        pif.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        run_window(0, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
